jt7759_adpcm: RTL and testbench
===============================

// Module: jt7759_adpcm
// PURPOSE
// ADPCM decoder stage of JT7759, directly downstream of jt7759_ctrl. Consumes one 4-bit
// ADPCM nibble per cendec tick (uPD7759 algorithm), keeps step state and sample
// accumulator, produces signed 14-bit sound for the top-level output. Two-stage
// clk-rate pipeline (table lookup, accumulate+saturate) hides table latency.
// PARAMETERS
// MUTE_ON_RST  1  1: dec_rst also clears sound to 0; 0: sound holds last value on dec_rst
// PORTS
// clk       in   1   system clock
// rstn      in   1   asynchronous reset, active low
// cendec    in   1   sample-rate clock enable from jt7759_div; one clk wide
// dec_rst   in   1   sync clear of decoder state (from ctrl at start of each phrase)
// dec_en    in   1   nibble valid; sampled only when cendec=1
// dec_din   in   4   ADPCM nibble: bit3 sign, bits2:0 magnitude index
// dec_done  out  1   one-clk pulse: new sample written to sound
// sound     out  14  signed output, = {sample[8:0], 5'b0}
// BEHAVIOUR
// - Reset (rstn=0): state=0, sample=0, pipeline valid flags=0, sound=0, dec_done=0.
// - Step table STEP[state][n], n=nibble[2:0]; value negated when nibble[3]=1 (8 => -0):
//   r0 0,0,1,2,3,5,7,10 | r1 0,1,2,3,4,6,8,13 | r2 0,1,2,4,5,7,10,15 | r3 0,1,3,4,6,9,13,19
//   r4 0,2,3,5,8,11,15,23 | r5 0,2,4,7,10,14,19,29 | r6 0,3,5,8,12,16,22,33 | r7 1,4,7,10,15,20,29,43
//   r8 1,4,8,13,18,25,35,53 | r9 1,6,10,16,22,31,43,64 | r10 2,7,12,19,27,37,51,76
//   r11 2,9,16,24,34,46,64,96 | r12 3,11,19,29,41,57,79,117 | r13 4,13,24,36,50,69,96,143
//   r14 4,16,29,44,62,85,118,175 | r15 6,20,36,54,76,104,144,214
// - State delta by n: -1,-1,0,0,+1,+2,+2,+3; next state saturates to 0..15 (no wrap).
// - Stage 1 (clk after cendec&dec_en&!dec_rst): register signed 9-bit step from current
//   state and dec_din; update state in the same cycle.
// - Stage 2 (next clk): sample <= sat9(sample + step), sum computed at 10 bits, saturated
//   to -256..255; sound <= {sample_new,5'b0}; dec_done=1 for that one cycle.
// - Latency: cendec edge -> sound update = 2 clk. cendec ticks are >=3 clk apart
//   (guaranteed by jt7759_div); back-to-back ticks are not supported.
// - cendec with dec_en=0: no state/sample change, no dec_done; sound holds.
// - dec_rst (any cycle, priority over everything): state=0, sample=0, stage-1 valid
//   cleared so an in-flight nibble is discarded (no dec_done). Sound cleared to 0 if
//   MUTE_ON_RST=1, else held. dec_rst together with cendec&dec_en: nibble dropped.
// - rstn assertion mid-pipeline: all regs to reset values immediately (async).
// - Outside cendec ticks dec_din/dec_en are don't-care.
// TESTING
// 1 rstn pulse, cendec idle -> sound=0, dec_done=0, internal state=0.
// 2 Six nibbles 7 from reset -> sample 10,29,62,126,243,255 (sat); sound 320..8160;
//   state 3,6,9,12,15,15; one dec_done per nibble, 2 clk after each cendec.
// 3 Six nibbles 15 from reset -> sample -10,-29,-62,-126,-243,-256; sound ends -8192.
// 4 Nibble 0 and 8 from state 0 -> sample unchanged 0, state stays 0 (floor clamp).
// 5 Three nibbles 7 then dec_rst on cycle after 4th cendec -> no 4th dec_done;
//   sound=0 (MUTE_ON_RST=1) or 1984 (=62<<5, MUTE_ON_RST=0); next nibble 7 -> 320.
// 6 cendec with dec_en=0 between nibbles -> no dec_done, sound and state unchanged.

Source files
------------

// File: rtl/jt7759_adpcm.sv
// ----------------------------------------------------------------------------
// jt7759_adpcm
// ADPCM decoder stage of JT7759 (uPD7759 algorithm). Takes one 4-bit nibble per
// cendec tick, tracks the step-size state (0..15) and a signed 9-bit sample
// accumulator, and drives a signed 14-bit sound output.
// The pipeline has two stages:
//   stage 1: table lookup and state update
//   stage 2: accumulate, saturate and output
// Ports:
//   clk       system clock
//   rstn      asynchronous reset, active low
//   cendec    sample-rate clock enable, one clk wide, ticks >= 3 clk apart
//   dec_rst   synchronous clear of decoder state; highest priority
//   dec_en    nibble valid, sampled only when cendec=1
//   dec_din   ADPCM nibble: bit3 sign, bits2:0 magnitude index
//   dec_done  one-clk pulse when a new sample is written to sound
//   sound     signed output, {sample[8:0], 5'b0}
// Parameter:
//   MUTE_ON_RST  1: dec_rst also clears sound; 0: sound holds on dec_rst
// ----------------------------------------------------------------------------
module jt7759_adpcm #(
  parameter bit MUTE_ON_RST = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cendec,
  input  logic               dec_rst,
  input  logic               dec_en,
  input  logic [3:0]         dec_din,
  output logic               dec_done,
  output logic signed [13:0] sound
);

  localparam logic [7:0] STEP_TABLE [0:15][0:7] = '{
    '{8'd0, 8'd0,  8'd1,  8'd2,  8'd3,  8'd5,   8'd7,   8'd10 },
    '{8'd0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd13 },
    '{8'd0, 8'd1,  8'd2,  8'd4,  8'd5,  8'd7,   8'd10,  8'd15 },
    '{8'd0, 8'd1,  8'd3,  8'd4,  8'd6,  8'd9,   8'd13,  8'd19 },
    '{8'd0, 8'd2,  8'd3,  8'd5,  8'd8,  8'd11,  8'd15,  8'd23 },
    '{8'd0, 8'd2,  8'd4,  8'd7,  8'd10, 8'd14,  8'd19,  8'd29 },
    '{8'd0, 8'd3,  8'd5,  8'd8,  8'd12, 8'd16,  8'd22,  8'd33 },
    '{8'd1, 8'd4,  8'd7,  8'd10, 8'd15, 8'd20,  8'd29,  8'd43 },
    '{8'd1, 8'd4,  8'd8,  8'd13, 8'd18, 8'd25,  8'd35,  8'd53 },
    '{8'd1, 8'd6,  8'd10, 8'd16, 8'd22, 8'd31,  8'd43,  8'd64 },
    '{8'd2, 8'd7,  8'd12, 8'd19, 8'd27, 8'd37,  8'd51,  8'd76 },
    '{8'd2, 8'd9,  8'd16, 8'd24, 8'd34, 8'd46,  8'd64,  8'd96 },
    '{8'd3, 8'd11, 8'd19, 8'd29, 8'd41, 8'd57,  8'd79,  8'd117},
    '{8'd4, 8'd13, 8'd24, 8'd36, 8'd50, 8'd69,  8'd96,  8'd143},
    '{8'd4, 8'd16, 8'd29, 8'd44, 8'd62, 8'd85,  8'd118, 8'd175},
    '{8'd6, 8'd20, 8'd36, 8'd54, 8'd76, 8'd104, 8'd144, 8'd214}
  };

  // State increment per magnitude index.
  localparam logic signed [2:0] STATE_DELTA [0:7] = '{
    -3'sd1, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd3
  };

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic signed [5:0] state_sum;
  logic signed [8:0] sample;
  logic signed [8:0] sample_nxt;
  logic signed [9:0] sum;
  logic [8:0]        step_mag;
  logic signed [8:0] step_nxt;
  logic signed [8:0] step_q;
  logic              s1_valid;
  logic              take;

  assign take = cendec & dec_en & ~dec_rst;

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    step_mag  = {1'b0, STEP_TABLE[state][dec_din[2:0]]};
    step_nxt  = step_mag;
    state_nxt = state;
    // Sign-extended delta added to a zero-extended state keeps the sum in -1..18.
    state_sum = $signed({2'b00, state}) +
                $signed({{3{STATE_DELTA[dec_din[2:0]][2]}}, STATE_DELTA[dec_din[2:0]]});
    if (dec_din[3]) step_nxt = -step_mag;       // nibble 8 yields -0 = 0
    if (state_sum < 6'sd0)       state_nxt = 4'd0;
    else if (state_sum > 6'sd15) state_nxt = 4'd15;
    else                         state_nxt = state_sum[3:0];
  end

  // The sum is formed at 10 bits so overflow of the 9-bit sample is visible,
  // then clamped to -256..255.
  always_comb begin
    sum        = {sample[8], sample} + {step_q[8], step_q};
    sample_nxt = sum[8:0];
    if (sum > 10'sd255)       sample_nxt = 9'sd255;
    else if (sum < -10'sd256) sample_nxt = -9'sd256;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= 4'd0;
      sample   <= 9'sd0;
      step_q   <= 9'sd0;
      s1_valid <= 1'b0;
      dec_done <= 1'b0;
      sound    <= 14'sd0;
    end else if (dec_rst) begin
      // An in-flight nibble is discarded here, so it produces no dec_done.
      state    <= 4'd0;
      sample   <= 9'sd0;
      s1_valid <= 1'b0;
      dec_done <= 1'b0;
      if (MUTE_ON_RST) sound <= 14'sd0;
    end else begin
      // Stage 1: lookup and state update.
      s1_valid <= take;
      if (take) begin
        step_q <= step_nxt;
        state  <= state_nxt;
      end
      // Stage 2: accumulate and publish.
      dec_done <= s1_valid;
      if (s1_valid) begin
        sample <= sample_nxt;
        sound  <= {sample_nxt, 5'b0};
      end
    end
  end

endmodule

// File: tb/tb_jt7759_adpcm.sv
module tb_jt7759_adpcm;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               cendec = 1'b0;
  logic               dec_rst = 1'b0;
  logic               dec_en = 1'b0;
  logic [3:0]         dec_din = 4'd0;
  logic               dec_done;
  logic signed [13:0] sound;
  logic               done_h;
  logic signed [13:0] sound_h;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jt7759_adpcm #(.MUTE_ON_RST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .cendec(cendec), .dec_rst(dec_rst),
    .dec_en(dec_en), .dec_din(dec_din), .dec_done(dec_done), .sound(sound)
  );

  jt7759_adpcm #(.MUTE_ON_RST(1'b0)) dut_hold (
    .clk(clk), .rstn(rstn), .cendec(cendec), .dec_rst(dec_rst),
    .dec_en(dec_en), .dec_din(dec_din), .dec_done(done_h), .sound(sound_h)
  );

  function automatic logic signed [13:0] snd(input logic signed [8:0] s);
    return {s, 5'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; cendec = 1'b0; dec_en = 1'b0; dec_rst = 1'b0; dec_din = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One cendec tick. done_at is the negedge index (1 = just after the sampling
  // edge) where dec_done is first seen, -1 if never; done_cnt counts pulses over
  // a bounded window of four cycles.
  task automatic tick(input logic en, input logic [3:0] n,
                      output int done_at, output int done_cnt);
    @(negedge clk);
    cendec = 1'b1; dec_en = en; dec_din = n;
    done_at = -1; done_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin cendec = 1'b0; dec_en = 1'b0; dec_din = 4'd0; end
      if (dec_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
  endtask

  task automatic check_nibble(input string name, input logic [3:0] n,
                              input logic signed [8:0] exp_s, input logic [3:0] exp_st);
    int at, cnt;
    tick(1'b1, n, at, cnt);
    checks++;
    if (sound !== snd(exp_s)) begin
      failures++; $display("FAIL %s sound got=%0d exp=%0d", name, sound, snd(exp_s));
    end
    checks++;
    if (dut.state !== exp_st) begin
      failures++; $display("FAIL %s state got=%0d exp=%0d", name, dut.state, exp_st);
    end
    checks++;
    if (at !== 2) begin
      failures++; $display("FAIL %s done_latency got=%0d exp=2", name, at);
    end
    checks++;
    if (cnt !== 1) begin
      failures++; $display("FAIL %s done_count got=%0d exp=1", name, cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sound !== 14'sd0) begin failures++; $display("FAIL reset sound got=%0d exp=0", sound); end
    checks++;
    if (dec_done !== 1'b0) begin failures++; $display("FAIL reset dec_done got=%b exp=0", dec_done); end
    checks++;
    if (dut.state !== 4'd0) begin failures++; $display("FAIL reset state got=%0d exp=0", dut.state); end
  endtask

  task automatic test_positive_ramp();
    logic signed [8:0] es [6] = '{9'sd10, 9'sd29, 9'sd62, 9'sd126, 9'sd243, 9'sd255};
    logic [3:0]        est [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
    do_reset();
    for (int i = 0; i < 6; i++) check_nibble($sformatf("pos%0d", i), 4'd7, es[i], est[i]);
  endtask

  task automatic test_negative_ramp();
    logic signed [8:0] es [6] = '{-9'sd10, -9'sd29, -9'sd62, -9'sd126, -9'sd243, -9'sd256};
    logic [3:0]        est [6] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};
    do_reset();
    for (int i = 0; i < 6; i++) check_nibble($sformatf("neg%0d", i), 4'd15, es[i], est[i]);
    checks++;
    if (sound !== -14'sd8192) begin
      failures++; $display("FAIL neg_final sound got=%0d exp=-8192", sound);
    end
  endtask

  task automatic test_floor_clamp();
    do_reset();
    check_nibble("floor_n0", 4'd0, 9'sd0, 4'd0);
    check_nibble("floor_n8", 4'd8, 9'sd0, 4'd0);
  endtask

  task automatic test_dec_rst_drop();
    int cnt, cnt_h;
    do_reset();
    check_nibble("rst_a", 4'd7, 9'sd10, 4'd3);
    check_nibble("rst_b", 4'd7, 9'sd29, 4'd6);
    check_nibble("rst_c", 4'd7, 9'sd62, 4'd9);
    @(negedge clk);
    cendec = 1'b1; dec_en = 1'b1; dec_din = 4'd7;
    @(negedge clk);
    cendec = 1'b0; dec_en = 1'b0; dec_din = 4'd0; dec_rst = 1'b1;
    cnt = 0; cnt_h = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dec_rst = 1'b0;
      if (dec_done) cnt++;
      if (done_h) cnt_h++;
    end
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL rst_drop done_count got=%0d exp=0", cnt); end
    checks++;
    if (cnt_h !== 0) begin failures++; $display("FAIL rst_drop_hold done_count got=%0d exp=0", cnt_h); end
    checks++;
    if (sound !== 14'sd0) begin failures++; $display("FAIL rst_mute sound got=%0d exp=0", sound); end
    checks++;
    if (sound_h !== 14'sd1984) begin
      failures++; $display("FAIL rst_hold sound got=%0d exp=1984", sound_h);
    end
    checks++;
    if (dut.state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state); end
    check_nibble("rst_after", 4'd7, 9'sd10, 4'd3);
    checks++;
    if (sound_h !== 14'sd320) begin
      failures++; $display("FAIL rst_after_hold sound got=%0d exp=320", sound_h);
    end
  endtask

  task automatic test_idle_tick();
    int at, cnt;
    do_reset();
    check_nibble("idle_a", 4'd5, 9'sd5, 4'd2);
    tick(1'b0, 4'd7, at, cnt);
    checks++;
    if (cnt !== 0) begin failures++; $display("FAIL idle done_count got=%0d exp=0", cnt); end
    checks++;
    if (sound !== snd(9'sd5)) begin failures++; $display("FAIL idle sound got=%0d exp=160", sound); end
    checks++;
    if (dut.state !== 4'd2) begin failures++; $display("FAIL idle state got=%0d exp=2", dut.state); end
    // state 2, n=5 -> step 7, sample 12, state 4
    check_nibble("idle_b", 4'd5, 9'sd12, 4'd4);
  endtask

  initial begin
    test_reset();
    test_positive_ramp();
    test_negative_ramp();
    test_floor_clamp();
    test_dec_rst_drop();
    test_idle_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
